// File: rtl/core_pkg.sv
// Shared types for the data-memory load/store path: access size, LSU FSM
// states and the default memory address width.
package core_pkg;

  localparam int ADDR_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling for the LSU: little-endian lane extraction with
// sign/zero extension for loads, and lane merge into a read word for
// sub-word stores.
module lsu_align
  import core_pkg::*;
(
  input  mem_size_t   i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [31:0] w_shift;

  // Shift the addressed lane down to bit 0 and extend it to 32 bits.
  always_comb begin
    w_shift = i_rword >> {i_lane, 3'b000};
    case (i_size)
      SIZE_B:  o_load = {{24{~i_unsigned & w_shift[7]}}, w_shift[7:0]};
      SIZE_H:  o_load = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
      default: o_load = i_rword;
    endcase
  end

  // Replace only the addressed lane of the read word with store data.
  always_comb begin
    o_merge = i_rword;
    case (i_size)
      SIZE_B:  o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      SIZE_H:  o_merge[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory bus initiator: one load/store at a time, word-aligned address,
// single-cycle read/write strobes, tri-state data bus, and read-modify-write
// for byte/halfword stores.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return
// an error response without touching memory; otherwise low address bits
// beyond the access size are cleared and the access proceeds.
module load_store_unit
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  inout  tri   [31:0]           mem_bus_io,
  output logic                  mem_re_o,
  output logic                  mem_we_o
);

  lsu_state_t            r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_lane;
  mem_size_t             r_size;
  logic                  r_unsigned;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;

  mem_size_t             w_size;
  logic [1:0]            w_lane;
  logic                  w_misalign;
  logic                  w_accept;
  logic [31:0]           w_load;
  logic [31:0]           w_merge;
  logic                  w_unused;

  // Upper request address bits beyond the memory width are dropped.
  assign w_unused = &{1'b0, req_addr_i[31:ADDR_WIDTH]};
  assign w_accept = req_valid_i & req_ready_o;

  // Decode request size (11 behaves as word), aligned lane and misalignment.
  always_comb begin
    case (req_size_i)
      2'b00:   w_size = SIZE_B;
      2'b01:   w_size = SIZE_H;
      default: w_size = SIZE_W;
    endcase
    case (w_size)
      SIZE_B:  w_lane = req_addr_i[1:0];
      SIZE_H:  w_lane = {req_addr_i[1], 1'b0};
      default: w_lane = 2'b00;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign = ((w_size == SIZE_H) & req_addr_i[0]) |
                 ((w_size == SIZE_W) & (req_addr_i[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
  end

  // State register; async reset drops the strobes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and strobe/handshake decode.
  always_comb begin
    w_next       = r_state;
    req_ready_o  = 1'b0;
    mem_re_o     = 1'b0;
    mem_we_o     = 1'b0;
    resp_valid_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (w_misalign)         w_next = ST_RESP;
          else if (!req_we_i)     w_next = ST_READ;
          else if (w_size == SIZE_W) w_next = ST_WRITE;
          else                    w_next = ST_RMW_RD;
        end
      end
      ST_READ: begin
        mem_re_o = 1'b1;
        w_next   = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_re_o = 1'b1;
        w_next   = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we_o = 1'b1;
        w_next   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, load capture and sub-word merge of the read word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_lane     <= 2'b00;
      r_size     <= SIZE_W;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
      r_lane     <= w_lane;
      r_size     <= w_size;
      r_unsigned <= req_unsigned_i;
      r_wdata    <= req_wdata_i;
      r_rdata    <= '0;
      r_err      <= w_misalign;
    end else if (r_state == ST_READ) begin
      r_rdata    <= w_load;
    end else if (r_state == ST_RMW_RD) begin
      r_wdata    <= w_merge;
    end
  end

  lsu_align u_align (
    .i_size     (r_size),
    .i_lane     (r_lane),
    .i_unsigned (r_unsigned),
    .i_rword    (mem_bus_io),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  assign mem_addr_o   = r_addr;
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = (r_state == ST_RESP) & r_err;
  assign mem_bus_io   = mem_we_o ? r_wdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit paired with a small word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b10;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [15:0] mem_addr_o;
  tri   [31:0] mem_bus_io;
  logic        mem_re_o;
  logic        mem_we_o;

  logic [31:0] mem [0:255];
  int n_cmp = 0;
  int n_err = 0;
  int re_cnt = 0;
  int we_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_bus_io     (mem_bus_io),
    .mem_re_o       (mem_re_o),
    .mem_we_o       (mem_we_o)
  );

  // Memory model: combinational read onto the bus, write on posedge.
  assign mem_bus_io = mem_re_o ? mem[mem_addr_o[9:2]] : 32'hzzzz_zzzz;
  always @(posedge clk) if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_bus_io;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Every cycle: strobes exclusive; count strobe cycles per transaction.
  always @(negedge clk) begin
    if (!rst) begin
      chk("strobe_excl", {31'b0, mem_re_o & mem_we_o}, 32'h0);
      if (mem_re_o) re_cnt++;
      if (mem_we_o) we_cnt++;
    end
  end

  task automatic run(input string tag, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic err,
                     output logic [31:0] maddr);
    @(negedge clk);
    re_cnt = 0; we_cnt = 0;
    req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = a; req_wdata_i = wd; req_valid_i = 1'b1;
    chk({tag, "_rdy_idle"}, {31'b0, req_ready_o}, 32'h1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    maddr = {16'h0, mem_addr_o};
    lat = 0; rd = '0; err = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk({tag, "_rdy_busy"}, {31'b0, req_ready_o}, 32'h0);
      if (resp_valid_o) begin
        lat = i; rd = resp_rdata_o; err = resp_err_o;
        break;
      end
    end
    if (lat == 0) chk({tag, "_timeout"}, 32'h0, 32'h1);
    @(negedge clk);
    chk({tag, "_rdy_back"}, {31'b0, req_ready_o}, 32'h1);
    chk({tag, "_vld_once"}, {31'b0, resp_valid_o}, 32'h0);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        err;
  logic [31:0] ma;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'hDEADBEEF;
    mem[8'h0C] = 32'hCAFEF00D;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready_o}, 32'h1);
    chk("rst_valid", {31'b0, resp_valid_o}, 32'h0);
    chk("rst_rdata", resp_rdata_o, 32'h0);
    chk("rst_err",   {31'b0, resp_err_o}, 32'h0);
    chk("rst_addr",  {16'h0, mem_addr_o}, 32'h0);
    chk("rst_strb",  {30'b0, mem_re_o, mem_we_o}, 32'h0);
    rst = 1'b0;

    run("lw10", 1'b0, 2'b10, 1'b0, 32'h0010, 0, lat, rd, err, ma);
    chk("lw10_lat", lat, 2);
    chk("lw10_data", rd, 32'hDEADBEEF);
    chk("lw10_addr", ma, 32'h0010);
    chk("lw10_re", re_cnt, 1);
    chk("lw10_we", we_cnt, 0);

    run("lb13", 1'b0, 2'b00, 1'b0, 32'h0013, 0, lat, rd, err, ma);
    chk("lb13_data", rd, 32'hFFFFFFDE);
    run("lbu13", 1'b0, 2'b00, 1'b1, 32'h0013, 0, lat, rd, err, ma);
    chk("lbu13_data", rd, 32'h000000DE);
    run("lh12", 1'b0, 2'b01, 1'b0, 32'h0012, 0, lat, rd, err, ma);
    chk("lh12_data", rd, 32'hFFFFDEAD);
    run("lhu10", 1'b0, 2'b01, 1'b1, 32'h0010, 0, lat, rd, err, ma);
    chk("lhu10_data", rd, 32'h0000BEEF);
    run("lb10", 1'b0, 2'b00, 1'b0, 32'h0010, 0, lat, rd, err, ma);
    chk("lb10_data", rd, 32'hFFFFFFEF);
    run("lw11size", 1'b0, 2'b11, 1'b0, 32'h0010, 0, lat, rd, err, ma);
    chk("lw11size_data", rd, 32'hDEADBEEF);

    run("sb11", 1'b1, 2'b00, 1'b0, 32'h0011, 32'h00000055, lat, rd, err, ma);
    chk("sb11_lat", lat, 3);
    chk("sb11_mem", mem[8'h04], 32'hDEAD55EF);
    chk("sb11_re", re_cnt, 1);
    chk("sb11_we", we_cnt, 1);
    chk("sb11_rdata", rd, 32'h0);

    run("sh12", 1'b1, 2'b01, 1'b0, 32'h0012, 32'hFFFFA5A5, lat, rd, err, ma);
    chk("sh12_lat", lat, 3);
    chk("sh12_mem", mem[8'h04], 32'hA5A555EF);

    run("sw20", 1'b1, 2'b10, 1'b0, 32'h0020, 32'h12345678, lat, rd, err, ma);
    chk("sw20_lat", lat, 2);
    chk("sw20_mem", mem[8'h08], 32'h12345678);
    chk("sw20_re", re_cnt, 0);
    chk("sw20_we", we_cnt, 1);
    run("lw20", 1'b0, 2'b10, 1'b0, 32'h0020, 0, lat, rd, err, ma);
    chk("lw20_data", rd, 32'h12345678);

    run("lw22", 1'b0, 2'b10, 1'b0, 32'h0022, 0, lat, rd, err, ma);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw22_lat", lat, 1);
    chk("lw22_err", {31'b0, err}, 32'h1);
    chk("lw22_data", rd, 32'h0);
    chk("lw22_strb", re_cnt + we_cnt, 0);
`else
    chk("lw22_lat", lat, 2);
    chk("lw22_err", {31'b0, err}, 32'h0);
    chk("lw22_data", rd, 32'h12345678);
    chk("lw22_re", re_cnt, 1);
`endif

    // Abort a word store with reset while its write strobe is up.
    @(negedge clk);
    req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h0030; req_wdata_i = 32'h11111111; req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    chk("abort_we_up", {31'b0, mem_we_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("abort_we_drop", {31'b0, mem_we_o}, 32'h0);
    chk("abort_ready", {31'b0, req_ready_o}, 32'h1);
    chk("abort_valid", {31'b0, resp_valid_o}, 32'h0);
    @(posedge clk);
    #1;
    chk("abort_mem", mem[8'h0C], 32'hCAFEF00D);
    @(negedge clk);
    rst = 1'b0;
    run("lw30", 1'b0, 2'b10, 1'b0, 32'h0030, 0, lat, rd, err, ma);
    chk("lw30_data", rd, 32'hCAFEF00D);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
